lb_config_ctrl: RTL and testbench
=================================

# lb_config_ctrl

Configuration controller for an array of LUT4 logic blocks. Accepts a framed configuration stream over a valid/ready handshake, stages each block's 16-bit LUT truth table and output-select bit in shadow registers, verifies an XOR checksum, then commits atomically to the per-block `sramConfig`/`sel` inputs. The fabric never sees a partial or corrupt configuration. Sits between the external bitstream source and the logic-block array.

## Interface
Parameters:
- `NUM_LB`, 8: number of logic blocks driven; legal range 1..16.
- `CW`, 16: config word width per block; fixed to the LUT4 truth-table size.

Ports:
- `clk`  in  1  single clock for the block.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a load session; sampled only in IDLE.
- `s_data`  in  16  stream word.
- `s_valid`  in  1  stream word valid.
- `s_ready`  out  1  controller can accept a word.
- `lb_cfg`  out  NUM_LB*CW  committed truth tables; block i at bits [i*CW +: CW].
- `lb_sel`  out  NUM_LB  committed output select; bit i = registered/combinational choice for block i.
- `lb_en`  out  1  fabric enable; high once any configuration has committed.
- `busy`  out  1  session in progress.
- `done`  out  1  one-cycle pulse on successful commit.
- `err`  out  1  sticky error flag; cleared on the next accepted `start`.
- `loaded_cnt`  out  5  block count of the last committed configuration.

## Operation
- Frame: header, N config words, one select word, one checksum word.
  - Header: `[15:8]` = SYNC (0xA5), `[7:0]` = N, with 1 ≤ N ≤ NUM_LB.
  - Config word k goes to block k.
  - Select word: bit i goes to `lb_sel[i]`. Bits ≥ NUM_LB are ignored.
  - Checksum: XOR of every preceding word in the frame, header included.
- States: IDLE, HDR, CFG, SEL, CHK.
  - IDLE→HDR on `start`. This clears the shadow registers, the running XOR and `err`.
  - HDR: a header with bad sync, N=0 or N>NUM_LB → IDLE with `err`=1. Otherwise → CFG with index=0.
  - CFG: each accepted word is written to shadow[index] and the index increments. After word N-1 → SEL.
  - SEL: accepted word is written to shadow sel → CHK.
  - CHK: if the accepted word equals the running XOR, commit and → IDLE. On mismatch → IDLE with `err`=1 and no commit.
- Commit:
  - `lb_cfg` ← shadow, `lb_sel` ← shadow sel, `loaded_cnt` ← N.
  - `lb_en` ← 1.
  - `done` pulses for one cycle.
- Blocks with index ≥ N commit as cfg 0x0000 and sel 0.
- Words are consumed only when `s_valid & s_ready`. Stalls of any length are legal.
- `start` while `busy` is ignored.
- On error, the active outputs and `lb_en` keep their previous values.

## Timing
- Reset values: `lb_cfg`=0, `lb_sel`=0, `lb_en`=0, `busy`=0, `done`=0, `err`=0, `loaded_cnt`=0, `s_ready`=0, state IDLE.
- Reset asserted mid-session aborts everything immediately. No commit occurs.
- `s_ready` is a registered-state decode: 1 in HDR/CFG/SEL/CHK, 0 in IDLE.
- `busy` is 1 outside IDLE.
- `start` at edge t gives `s_ready`=1 from cycle t+1.
- With continuous `s_valid`, a frame takes N+3 handshake cycles.
- Commit edge = the edge that accepts a valid checksum. `lb_cfg`, `lb_sel`, `done`=1 and `busy`=0 are all visible in the following cycle.
- `err` rises in the cycle after the offending handshake.
- `start` in the same cycle as the commit/error return to IDLE is not seen; it must arrive while IDLE.

## Structure
- Package `lb_cfg_pkg` holds:
  - the state enum;
  - `SYNC` = 8'hA5;
  - `CW` = 16;
  - the `loaded_cnt` width constant.
- Sub-module `cfg_xor_acc` holds the running checksum. Interface: clear, word-valid strobe, 16-bit data, 16-bit accumulated value.
- Shadow and active register banks stay in the top module.

## Test plan
Use NUM_LB=8 throughout.
- **Good load:** `start`; words 0xA502, 0x8000, 0x6996, 0x0002, 0x4C96.
  - Cycle after the last handshake: `done`=1, `lb_cfg[15:0]`=0x8000, `lb_cfg[31:16]`=0x6996, others 0.
  - `lb_sel`=0x02, `loaded_cnt`=2, `lb_en`=1.
- **Bad checksum:** good load, then a second frame ending in 0x4C97.
  - Result: `err`=1, no `done`, outputs still hold the first load.
- **Bad header:** 0x5A02 → `err`=1 and IDLE. Then 0xA509 → `err`=1. Then 0xA500 → `err`=1. `lb_en` stays 0 throughout.
- **Backpressure:** good-load frame with `s_valid` high every third cycle → identical commit values. No word is lost or duplicated.
- **Reset mid-load:** assert `reset` low after 0x8000 is accepted.
  - All outputs return to 0.
  - A following good load commits correctly.
- **Start while busy:** pulse `start` during CFG → ignored; frame completes normally and the shadow registers are not cleared.

Source files
------------

// File: rtl/lb_cfg_pkg.sv
// lb_cfg_pkg: shared constants and types for the logic-block configuration
// controller.
//   CW      - width of one LUT4 truth table, in bits
//   SYNC    - marker expected in header bits [15:8]
//   CNT_W   - width of the committed block count
//   state_t - load-session states
package lb_cfg_pkg;

  localparam int         CW    = 16;
  localparam logic [7:0] SYNC  = 8'hA5;
  localparam int         CNT_W = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_CFG,
    ST_SEL,
    ST_CHK
  } state_t;

endpackage

// File: rtl/cfg_xor_acc.sv
// cfg_xor_acc: running XOR checksum over the words of one configuration frame.
// Ports:
//   clk, reset - clock; asynchronous active-low reset
//   i_clear    - zero the accumulator (start of a session)
//   i_valid    - fold i_data into the accumulator this cycle
//   i_data     - stream word
//   o_acc      - XOR of every word folded in since the last clear
module cfg_xor_acc
  import lb_cfg_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          i_clear,
  input  logic          i_valid,
  input  logic [CW-1:0] i_data,
  output logic [CW-1:0] o_acc
);

  logic [CW-1:0] r_acc;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc <= '0;
    end else if (i_clear) begin
      r_acc <= '0;
    end else if (i_valid) begin
      r_acc <= r_acc ^ i_data;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/lb_config_ctrl.sv
// lb_config_ctrl: loads a framed configuration stream into shadow registers,
// verifies its XOR checksum and commits it atomically to the LUT4 array.
// Frame: header {SYNC, N}, N config words, one select word, one checksum word.
// Ports:
//   clk, reset       - clock; asynchronous active-low reset
//   start            - begin a load session (honoured only in IDLE)
//   s_data/s_valid   - stream word and its valid
//   s_ready          - controller accepts a word (any non-IDLE state)
//   lb_cfg           - committed truth tables, block i at [i*CW +: CW]
//   lb_sel           - committed output-select bits
//   lb_en            - high once any configuration has committed
//   busy             - session in progress
//   done             - one-cycle pulse after a successful commit
//   err              - sticky error, cleared by the next accepted start
//   loaded_cnt       - block count of the last committed configuration
module lb_config_ctrl
  import lb_cfg_pkg::*;
#(
  parameter int NUM_LB = 8,
  parameter int CW     = lb_cfg_pkg::CW
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [CW-1:0]        s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic [NUM_LB*CW-1:0] lb_cfg,
  output logic [NUM_LB-1:0]    lb_sel,
  output logic                 lb_en,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [CNT_W-1:0]     loaded_cnt
);

  state_t r_state, w_next;

  // Shadow bank: filled during the session, invisible to the fabric.
  logic [CW-1:0]        r_shadow [NUM_LB];
  logic [NUM_LB-1:0]    r_shadow_sel;
  logic [CNT_W-1:0]     r_n;
  logic [CNT_W-1:0]     r_idx;

  // Active bank: what the fabric sees.
  logic [NUM_LB*CW-1:0] r_cfg;
  logic [NUM_LB-1:0]    r_sel;
  logic                 r_en;
  logic                 r_done;
  logic                 r_err;
  logic [CNT_W-1:0]     r_cnt;

  logic          w_fire, w_start, w_hdr_ok, w_chk_ok, w_commit, w_fail;
  logic [CW-1:0] w_acc;

  assign s_ready  = (r_state != ST_IDLE);
  assign w_fire   = s_valid & s_ready;
  assign w_start  = (r_state == ST_IDLE) & start;
  assign w_hdr_ok = (s_data[15:8] == SYNC) && (s_data[7:0] != 8'd0) &&
                    (s_data[7:0] <= 8'(NUM_LB));
  assign w_chk_ok = (s_data == w_acc);
  assign w_commit = w_fire & (r_state == ST_CHK) & w_chk_ok;
  assign w_fail   = w_fire & (((r_state == ST_HDR) & ~w_hdr_ok) |
                              ((r_state == ST_CHK) & ~w_chk_ok));

  // The checksum word itself is never folded into the running XOR.
  cfg_xor_acc u_xor_acc (
    .clk     (clk),
    .reset   (reset),
    .i_clear (w_start),
    .i_valid (w_fire & (r_state != ST_CHK)),
    .i_data  (s_data),
    .o_acc   (w_acc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // NOTE: w_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (start)  w_next = ST_HDR;
      ST_HDR:  if (w_fire) w_next = w_hdr_ok ? ST_CFG : ST_IDLE;
      ST_CFG:  if (w_fire && (r_idx == r_n - CNT_W'(1))) w_next = ST_SEL;
      ST_SEL:  if (w_fire) w_next = ST_CHK;
      ST_CHK:  if (w_fire) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // NOTE: the shadow bank is small, so it gets an asynchronous reset like
  // every other flop; it is also cleared on each accepted start so blocks
  // at or above N commit as zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_LB; i++) r_shadow[i] <= '0;
      r_shadow_sel <= '0;
      r_n          <= '0;
      r_idx        <= '0;
      r_cfg        <= '0;
      r_sel        <= '0;
      r_en         <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_cnt        <= '0;
    end else begin
      r_done <= w_commit;

      if (w_start) begin
        for (int i = 0; i < NUM_LB; i++) r_shadow[i] <= '0;
        r_shadow_sel <= '0;
        r_err        <= 1'b0;
      end

      if (w_fire) begin
        case (r_state)
          ST_HDR: begin
            r_n   <= s_data[CNT_W-1:0];
            r_idx <= '0;
          end
          ST_CFG: begin
            for (int i = 0; i < NUM_LB; i++)
              if (r_idx == CNT_W'(i)) r_shadow[i] <= s_data;
            r_idx <= r_idx + CNT_W'(1);
          end
          ST_SEL:  r_shadow_sel <= s_data[NUM_LB-1:0];
          default: ;
        endcase
      end

      // Active bank changes only here, so the fabric never sees a partial load.
      if (w_commit) begin
        for (int i = 0; i < NUM_LB; i++) r_cfg[i*CW +: CW] <= r_shadow[i];
        r_sel <= r_shadow_sel;
        r_cnt <= r_n;
        r_en  <= 1'b1;
      end

      if (w_fail) r_err <= 1'b1;
    end
  end

  assign busy       = s_ready;
  assign lb_cfg     = r_cfg;
  assign lb_sel     = r_sel;
  assign lb_en      = r_en;
  assign done       = r_done;
  assign err        = r_err;
  assign loaded_cnt = r_cnt;

endmodule

// File: tb/tb_lb_config_ctrl.sv
// tb_lb_config_ctrl: scoreboard bench for lb_config_ctrl with NUM_LB=8.
// The driver computes each frame's expected outcome from a frame-level model
// and queues it; a monitor pops and compares on every done pulse or err rise.
module tb_lb_config_ctrl;

  localparam int NLB = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [15:0]    s_data;
  logic           s_valid;
  logic           s_ready;
  logic [NLB*16-1:0] lb_cfg;
  logic [NLB-1:0] lb_sel;
  logic           lb_en, busy, done, err;
  logic [4:0]     loaded_cnt;

  lb_config_ctrl #(.NUM_LB(NLB)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .lb_cfg     (lb_cfg),
    .lb_sel     (lb_sel),
    .lb_en      (lb_en),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .loaded_cnt (loaded_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic           is_commit;
    logic [127:0]   cfg;
    logic [7:0]     sel;
    logic [4:0]     cnt;
    logic           en;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] frame_q[$];

  // Model of the committed fabric state.
  logic [127:0] m_cfg = '0;
  logic [7:0]   m_sel = '0;
  logic [4:0]   m_cnt = '0;
  logic         m_en  = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  logic prev_err  = 1'b0;
  logic prev_done = 1'b0;
  exp_t mon_e;

  always @(negedge clk) begin
    if (!reset) begin
      prev_err  = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (prev_done) check("done_one_cycle", 128'(done), 128'(0));
      if (done || (err && !prev_err)) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_event done=%0b err=%0b expected=none", done, err);
        end else begin
          mon_e = exp_q.pop_front();
          check("event_kind", 128'({done, err}), 128'(mon_e.is_commit ? 2'b10 : 2'b01));
          check("lb_cfg",     lb_cfg,            mon_e.cfg);
          check("lb_sel",     128'(lb_sel),      128'(mon_e.sel));
          check("loaded_cnt", 128'(loaded_cnt),  128'(mon_e.cnt));
          check("lb_en",      128'(lb_en),       128'(mon_e.en));
          check("busy_after", 128'(busy),        128'(0));
        end
      end
      prev_done = done;
      prev_err  = err;
    end
  end

  // ---------------- reference model ----------------
  // Decides the outcome of frame_q from the framing rules alone and queues it.
  task automatic expect_frame();
    logic [15:0] hdr, x;
    int nn;
    exp_t e;
    hdr = frame_q[0];
    nn  = int'(hdr[7:0]);
    if (hdr[15:8] != 8'hA5 || nn < 1 || nn > NLB) begin
      while (frame_q.size() > 1) void'(frame_q.pop_back());
      e = '{is_commit: 1'b0, cfg: m_cfg, sel: m_sel, cnt: m_cnt, en: m_en};
    end else begin
      x = '0;
      for (int i = 0; i < nn + 2; i++) x ^= frame_q[i];
      if (frame_q[nn+2] == x) begin
        m_cfg = '0;
        for (int k = 0; k < nn; k++) m_cfg[k*16 +: 16] = frame_q[1+k];
        m_sel = frame_q[nn+1][7:0];
        m_cnt = 5'(nn);
        m_en  = 1'b1;
        e = '{is_commit: 1'b1, cfg: m_cfg, sel: m_sel, cnt: m_cnt, en: m_en};
      end else begin
        e = '{is_commit: 1'b0, cfg: m_cfg, sel: m_sel, cnt: m_cnt, en: m_en};
      end
    end
    exp_q.push_back(e);
  endtask

  // ---------------- driver ----------------
  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w, input int gap);
    bit acc;
    int t;
    repeat (gap) begin @(posedge clk); #1; end
    s_valid = 1'b1;
    s_data  = w;
    acc = 1'b0;
    t   = 0;
    while (!acc && t < 200) begin
      acc = s_ready;
      @(posedge clk); #1;
      t++;
    end
    s_valid = 1'b0;
    s_data  = 16'($urandom);
    if (!acc) check("handshake_timeout", 128'(acc), 128'(1));
  endtask

  task automatic wait_resp();
    int t = 0;
    while (exp_q.size() > 0 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    check("resp_timeout", 128'(exp_q.size()), 128'(0));
    exp_q.delete();
  endtask

  // gap < 0 picks a random 0..3 idle cycles before each word.
  task automatic play(input int gap, input bit poke);
    expect_frame();
    do_start();
    for (int i = 0; i < frame_q.size(); i++) begin
      if (poke && i == 2) start = 1'b1;
      send_word(frame_q[i], (gap < 0) ? int'($urandom_range(0, 3)) : gap);
      start = 1'b0;
    end
    wait_resp();
  endtask

  task automatic build_random();
    int n, r;
    logic [15:0] x, hdr;
    n = int'($urandom_range(1, NLB));
    r = int'($urandom_range(0, 9));
    hdr = {8'hA5, 8'(n)};
    if (r == 0) hdr[15:8] = 8'hA5 ^ 8'($urandom_range(1, 255));
    if (r == 1) hdr[7:0]  = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(9, 255));
    frame_q.delete();
    frame_q.push_back(hdr);
    for (int k = 0; k < n + 1; k++) frame_q.push_back(16'($urandom));
    x = '0;
    foreach (frame_q[i]) x ^= frame_q[i];
    if (r == 2) x ^= 16'(1 << $urandom_range(0, 15));
    frame_q.push_back(x);
  endtask

  task automatic good_frame();
    frame_q = '{16'hA502, 16'h8000, 16'h6996, 16'h0002, 16'h4C96};
  endtask

  initial begin
    reset   = 1'b0;
    start   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_lb_cfg",     lb_cfg,             128'(0));
    check("rst_lb_sel",     128'(lb_sel),       128'(0));
    check("rst_lb_en",      128'(lb_en),        128'(0));
    check("rst_busy",       128'(busy),         128'(0));
    check("rst_done",       128'(done),         128'(0));
    check("rst_err",        128'(err),          128'(0));
    check("rst_loaded_cnt", 128'(loaded_cnt),   128'(0));
    check("rst_s_ready",    128'(s_ready),      128'(0));
    reset = 1'b1;
    @(posedge clk); #1;

    // Bad headers: wrong sync, N above NUM_LB, N of zero.
    frame_q = '{16'h5A02}; play(0, 1'b0);
    frame_q = '{16'hA509}; play(0, 1'b0);
    frame_q = '{16'hA500}; play(0, 1'b0);
    check("lb_en_after_bad_hdr", 128'(lb_en), 128'(0));

    // Good load, then a corrupted-checksum frame that must leave it intact.
    good_frame(); play(0, 1'b0);
    check("cfg_blk0_direct", 128'(lb_cfg[15:0]),  128'(16'h8000));
    check("cfg_blk1_direct", 128'(lb_cfg[31:16]), 128'(16'h6996));
    frame_q = '{16'hA502, 16'h1234, 16'h5678, 16'h00FF, 16'h4C97}; play(0, 1'b0);

    // Backpressure: valid every third cycle.
    good_frame(); play(2, 1'b0);

    // Reset mid-load after 0x8000 is accepted.
    frame_q = '{16'hA503, 16'h1111, 16'h2222, 16'h3333, 16'h00AA, 16'h0000};
    do_start();
    send_word(16'hA502, 0);
    send_word(16'h8000, 0);
    reset = 1'b0;
    #1;
    m_cfg = '0; m_sel = '0; m_cnt = '0; m_en = 1'b0;
    check("mid_rst_lb_cfg",  lb_cfg,           128'(0));
    check("mid_rst_lb_sel",  128'(lb_sel),     128'(0));
    check("mid_rst_lb_en",   128'(lb_en),      128'(0));
    check("mid_rst_busy",    128'(busy),       128'(0));
    check("mid_rst_s_ready", 128'(s_ready),    128'(0));
    check("mid_rst_cnt",     128'(loaded_cnt), 128'(0));
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    good_frame(); play(0, 1'b0);

    // Start pulsed during CFG must be ignored without clearing the shadow bank.
    frame_q = '{16'hA504, 16'hDEAD, 16'hBEEF, 16'hCAFE, 16'hF00D, 16'h0005, 16'h0000};
    frame_q[6] = frame_q[0] ^ frame_q[1] ^ frame_q[2] ^ frame_q[3] ^ frame_q[4] ^ frame_q[5];
    play(0, 1'b1);

    // Randomized frames with random stalls and occasional stray starts.
    for (int f = 0; f < 40; f++) begin
      build_random();
      play(-1, $urandom_range(0, 1) == 1);
    end

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
